// File: rtl/dual_port_ram_pkg.sv
// Shared constants for the byte-writable dual-port RAM: read-during-write modes,
// conflict priority selectors and the byte-lane count helper.
package dual_port_ram_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;
  localparam int PRIO_PORT_A     = 0;
  localparam int PRIO_PORT_B     = 1;

  function automatic int nb(input int data_width, input int byte_w);
    return data_width / byte_w;
  endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read-return pipeline for one RAM port: RD_LATENCY stages of valid/data registers.
// Each data stage loads only when its input is valid, so data_out holds between reads.
module dp_ram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid
);

  logic [RD_LATENCY-1:0] valid_q;
  logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) data_q[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
      valid_q[0] <= rd_en;
      if (rd_en) data_q[0] <= rd_word;
      for (int s = 1; s < RD_LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
        if (valid_q[s-1]) data_q[s] <= data_q[s-1];
      end
    end
  end

  assign rd_valid = valid_q[RD_LATENCY-1];
  assign data_out = data_q[RD_LATENCY-1];

endmodule

// File: rtl/dual_port_ram_bytewr.sv
// Dual-port RAM with per-byte write enables, byte-wise write conflict resolution,
// per-port read-during-write mode, 1/2-cycle read latency and a conflict flag/counter.
module dual_port_ram_bytewr
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BYTE_W      = 8,
  parameter int ADDR_WIDTH  = 6,
  parameter int MEM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY  = 1,
  parameter int RDW_MODE_A  = RDW_WRITE_FIRST,
  parameter int RDW_MODE_B  = RDW_WRITE_FIRST,
  parameter int PRIO_B      = PRIO_PORT_A,
  parameter int CNT_W       = 8,
  parameter int INIT_ASCEND = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         write_en_a,
  input  logic                         read_en_a,
  input  logic [ADDR_WIDTH-1:0]        addr_a,
  input  logic [DATA_WIDTH-1:0]        data_in_a,
  input  logic [DATA_WIDTH/BYTE_W-1:0] byte_en_a,
  output logic [DATA_WIDTH-1:0]        data_out_a,
  output logic                         rd_valid_a,
  input  logic                         write_en_b,
  input  logic                         read_en_b,
  input  logic [ADDR_WIDTH-1:0]        addr_b,
  input  logic [DATA_WIDTH-1:0]        data_in_b,
  input  logic [DATA_WIDTH/BYTE_W-1:0] byte_en_b,
  output logic [DATA_WIDTH-1:0]        data_out_b,
  output logic                         rd_valid_b,
  input  logic                         clear_conflict,
  output logic                         conflict_flag,
  output logic [CNT_W-1:0]             conflict_count
);

  localparam int NB = nb(DATA_WIDTH, BYTE_W);

  typedef logic [DATA_WIDTH-1:0]                word_t;
  typedef logic [NB-1:0]                        lanes_t;
  typedef logic [MEM_DEPTH-1:0][DATA_WIDTH-1:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < MEM_DEPTH; i++) m[i] = (INIT_ASCEND != 0) ? word_t'(i) : '0;
    return m;
  endfunction

  function automatic word_t apply_lanes(input word_t base, input lanes_t mask, input word_t src);
    word_t w;
    w = base;
    for (int i = 0; i < NB; i++)
      if (mask[i]) w[i*BYTE_W +: BYTE_W] = src[i*BYTE_W +: BYTE_W];
    return w;
  endfunction

  // Initial contents only matter in simulation; hardware powers up undefined.
  mem_t mem = init_mem();

  logic   in_range_a, in_range_b, same_addr, conflict;
  lanes_t lane_hit_a, lane_hit_b, overlap, a_win, b_win;
  word_t  old_a, old_b, new_a, new_b, rd_word_a, rd_word_b;

  assign in_range_a = int'(addr_a) < MEM_DEPTH;
  assign in_range_b = int'(addr_b) < MEM_DEPTH;
  assign same_addr  = addr_a == addr_b;
  assign lane_hit_a = {NB{write_en_a}} & byte_en_a;
  assign lane_hit_b = {NB{write_en_b}} & byte_en_b;
  assign overlap    = {NB{same_addr}} & lane_hit_a & lane_hit_b;
  assign conflict   = |overlap;

  // The losing port gives up only the overlapping lanes; its other lanes still land.
  assign a_win = (PRIO_B == PRIO_PORT_B) ? (lane_hit_a & ~overlap) : lane_hit_a;
  assign b_win = (PRIO_B == PRIO_PORT_B) ? lane_hit_b : (lane_hit_b & ~overlap);

  assign old_a = in_range_a ? mem[addr_a] : '0;
  assign old_b = in_range_b ? mem[addr_b] : '0;
  assign new_a = apply_lanes(apply_lanes(old_a, a_win, data_in_a),
                             same_addr ? b_win : '0, data_in_b);
  assign new_b = apply_lanes(apply_lanes(old_b, b_win, data_in_b),
                             same_addr ? a_win : '0, data_in_a);

  assign rd_word_a = !in_range_a ? '0 : (RDW_MODE_A == RDW_READ_FIRST) ? old_a : new_a;
  assign rd_word_b = !in_range_b ? '0 : (RDW_MODE_B == RDW_READ_FIRST) ? old_b : new_b;

  // NOTE: the memory array is never reset; reset_n only blocks writes while it is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (reset_n) begin
      if (|lane_hit_a && in_range_a) mem[addr_a] <= new_a;
      if (|lane_hit_b && in_range_b) mem[addr_b] <= new_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_flag  <= 1'b0;
      conflict_count <= '0;
    end else if (clear_conflict) begin
      conflict_flag  <= conflict;
      conflict_count <= conflict ? CNT_W'(1) : '0;
    end else if (conflict) begin
      conflict_flag <= 1'b1;
      if (conflict_count != '1) conflict_count <= conflict_count + CNT_W'(1);
    end
  end

  dp_ram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_en    (read_en_a),
    .rd_word  (rd_word_a),
    .data_out (data_out_a),
    .rd_valid (rd_valid_a)
  );

  dp_ram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_en    (read_en_b),
    .rd_word  (rd_word_b),
    .data_out (data_out_b),
    .rd_valid (rd_valid_b)
  );

endmodule

// File: tb/tb_dual_port_ram_bytewr.sv
// Directed bench: u0 uses default parameters, u1 uses 2-cycle latency, read-first on
// port B, port-B priority and a 48-word depth; both see identical stimulus.
module tb_dual_port_ram_bytewr;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        write_en_a, read_en_a, write_en_b, read_en_b, clear_conflict;
  logic [5:0]  addr_a, addr_b;
  logic [31:0] data_in_a, data_in_b;
  logic [3:0]  byte_en_a, byte_en_b;

  logic [31:0] d0_a, d0_b, d1_a, d1_b;
  logic        v0_a, v0_b, v1_a, v1_b, f0, f1;
  logic [7:0]  c0, c1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dual_port_ram_bytewr u0 (
    .clk(clk), .reset_n(reset_n),
    .write_en_a(write_en_a), .read_en_a(read_en_a), .addr_a(addr_a), .data_in_a(data_in_a),
    .byte_en_a(byte_en_a), .data_out_a(d0_a), .rd_valid_a(v0_a),
    .write_en_b(write_en_b), .read_en_b(read_en_b), .addr_b(addr_b), .data_in_b(data_in_b),
    .byte_en_b(byte_en_b), .data_out_b(d0_b), .rd_valid_b(v0_b),
    .clear_conflict(clear_conflict), .conflict_flag(f0), .conflict_count(c0)
  );

  dual_port_ram_bytewr #(.MEM_DEPTH(48), .RD_LATENCY(2), .RDW_MODE_B(1), .PRIO_B(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .write_en_a(write_en_a), .read_en_a(read_en_a), .addr_a(addr_a), .data_in_a(data_in_a),
    .byte_en_a(byte_en_a), .data_out_a(d1_a), .rd_valid_a(v1_a),
    .write_en_b(write_en_b), .read_en_b(read_en_b), .addr_b(addr_b), .data_in_b(data_in_b),
    .byte_en_b(byte_en_b), .data_out_b(d1_b), .rd_valid_b(v1_b),
    .clear_conflict(clear_conflict), .conflict_flag(f1), .conflict_count(c1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    write_en_a = 0; read_en_a = 0; write_en_b = 0; read_en_b = 0; clear_conflict = 0;
    byte_en_a = '0; byte_en_b = '0;
  endtask

  task automatic write_a(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    write_en_a = 1; addr_a = a; data_in_a = d; byte_en_a = be;
    step();
    idle();
  endtask

  // Port-A read: u0 answers after one edge, u1 after two.
  task automatic read_a(input string tag, input logic [5:0] a,
                        input logic [31:0] exp0, input logic [31:0] exp1);
    read_en_a = 1; addr_a = a;
    step();
    read_en_a = 0;
    check({tag, " u0 valid"}, 32'(v0_a), 32'd1);
    check({tag, " u0 data"}, d0_a, exp0);
    check({tag, " u1 valid early"}, 32'(v1_a), 32'd0);
    step();
    check({tag, " u0 valid drop"}, 32'(v0_a), 32'd0);
    check({tag, " u1 valid"}, 32'(v1_a), 32'd1);
    check({tag, " u1 data"}, d1_a, exp1);
  endtask

  initial begin
    reset_n = 0; addr_a = '0; addr_b = '0; data_in_a = '0; data_in_b = '0;
    idle();
    // A write attempted during reset must be ignored.
    write_en_a = 1; addr_a = 6'd5; data_in_a = 32'hDEADBEEF; byte_en_a = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle();
    check("rst u0 flag", 32'(f0), 32'd0);
    check("rst u0 count", 32'(c0), 32'd0);
    check("rst u1 count", 32'(c1), 32'd0);
    check("rst u0 valid_a", 32'(v0_a), 32'd0);
    check("rst u1 valid_b", 32'(v1_b), 32'd0);
    check("rst u0 data_a", d0_a, 32'd0);
    check("rst u1 data_b", d1_b, 32'd0);
    reset_n = 1;

    read_a("init@5", 6'd5, 32'h00000005, 32'h00000005);
    check("hold u0 data_a", d0_a, 32'h00000005);

    write_a(6'd3, 32'hAABBCCDD, 4'b0101);
    read_a("bytewr@3", 6'd3, 32'h00BB00DD, 32'h00BB00DD);

    // Same address, disjoint masks: merge without conflict.
    write_en_a = 1; addr_a = 6'd7; data_in_a = 32'h11111111; byte_en_a = 4'b0011;
    write_en_b = 1; addr_b = 6'd7; data_in_b = 32'h22222222; byte_en_b = 4'b1100;
    step();
    idle();
    check("merge u0 flag", 32'(f0), 32'd0);
    check("merge u1 count", 32'(c1), 32'd0);
    read_a("merge@7", 6'd7, 32'h22221111, 32'h22221111);

    // Overlapping lanes 1 and 2: A wins in u0, B wins in u1.
    write_en_a = 1; addr_a = 6'd9; data_in_a = 32'hAAAAAAAA; byte_en_a = 4'b1111;
    write_en_b = 1; addr_b = 6'd9; data_in_b = 32'hBBBBBBBB; byte_en_b = 4'b0110;
    step();
    idle();
    check("conf u0 flag", 32'(f0), 32'd1);
    check("conf u0 count", 32'(c0), 32'd1);
    check("conf u1 flag", 32'(f1), 32'd1);
    check("conf u1 count", 32'(c1), 32'd1);
    read_a("conf@9", 6'd9, 32'hAAAAAAAA, 32'hAABBBBAA);

    // Zero byte enable at a shared address is neither a write nor a conflict.
    write_en_a = 1; addr_a = 6'd9; data_in_a = 32'h0; byte_en_a = 4'b0000;
    write_en_b = 1; addr_b = 6'd9; data_in_b = 32'h0; byte_en_b = 4'b1111;
    step();
    idle();
    check("be0 u0 count", 32'(c0), 32'd1);
    read_a("be0@9", 6'd9, 32'h00000000, 32'h00000000);

    // Cross-port read-during-write: u0 port B write-first, u1 port B read-first.
    write_en_a = 1; addr_a = 6'd4; data_in_a = 32'h00000055; byte_en_a = 4'hF;
    read_en_b = 1; addr_b = 6'd4;
    step();
    idle();
    check("rdw u0 valid_b", 32'(v0_b), 32'd1);
    check("rdw u0 data_b", d0_b, 32'h00000055);
    check("rdw u1 valid_b early", 32'(v1_b), 32'd0);
    step();
    check("rdw u1 valid_b", 32'(v1_b), 32'd1);
    check("rdw u1 data_b", d1_b, 32'h00000004);
    check("rdw u0 valid_b drop", 32'(v0_b), 32'd0);

    // Same-port read-during-write on A (write-first in both instances).
    write_en_a = 1; read_en_a = 1; addr_a = 6'd10; data_in_a = 32'h12345678; byte_en_a = 4'b1100;
    step();
    idle();
    check("rdw_a u0 data", d0_a, 32'h1234000A);
    step();
    check("rdw_a u1 data", d1_a, 32'h1234000A);

    // Address 50 is beyond u1's 48-word depth.
    write_a(6'd50, 32'hFFFFFFFF, 4'hF);
    read_a("oor@50", 6'd50, 32'hFFFFFFFF, 32'h00000000);

    clear_conflict = 1;
    step();
    idle();
    check("clr u0 flag", 32'(f0), 32'd0);
    check("clr u1 count", 32'(c1), 32'd0);

    write_en_a = 1; addr_a = 6'd20; data_in_a = 32'h1; byte_en_a = 4'hF;
    write_en_b = 1; addr_b = 6'd20; data_in_b = 32'h2; byte_en_b = 4'hF;
    repeat (260) step();
    check("sat u0 count", 32'(c0), 32'd255);
    check("sat u0 flag", 32'(f0), 32'd1);
    check("sat u1 count", 32'(c1), 32'd255);
    clear_conflict = 1;
    step();
    check("clr+conf u0 count", 32'(c0), 32'd1);
    check("clr+conf u0 flag", 32'(f0), 32'd1);
    check("clr+conf u1 count", 32'(c1), 32'd1);
    idle();
    step();
    check("conf stop u0 count", 32'(c0), 32'd1);

    // Reset between the two stages of a u1 port-B read.
    read_en_b = 1; addr_b = 6'd2;
    step();
    read_en_b = 0;
    check("pre-rst u0 data_b", d0_b, 32'h00000002);
    reset_n = 0;
    #1;
    check("async rst u0 data_b", d0_b, 32'd0);
    check("async rst u0 count", 32'(c0), 32'd0);
    write_en_a = 1; addr_a = 6'd11; data_in_a = 32'hFFFFFFFF; byte_en_a = 4'hF;
    step();
    idle();
    reset_n = 1;
    check("flush u1 valid_b 1", 32'(v1_b), 32'd0);
    step();
    check("flush u1 valid_b 2", 32'(v1_b), 32'd0);
    step();
    check("flush u1 valid_b 3", 32'(v1_b), 32'd0);
    read_a("rstwr@11", 6'd11, 32'h0000000B, 32'h0000000B);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
